// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if -- configuration write channel for led_pattern_gen.
//   cfg_valid  : write request (master -> slave)
//   cfg_ready  : write can be accepted (slave -> master)
//   cfg_ch     : target channel index
//   cfg_mode   : 0 OFF, 1 ON, 2 BLINK, 3 PWM
//   cfg_period : phase wrap value
//   cfg_duty   : PWM on-count
//   cfg_err    : one-cycle pulse after a write to a nonexistent channel
interface led_pattern_gen_if #(
   parameter int unsigned CNT_W = 8
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [4:0]       cfg_ch;
   logic [1:0]       cfg_mode;
   logic [CNT_W-1:0] cfg_period;
   logic [CNT_W-1:0] cfg_duty;
   logic             cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
      output cfg_ready, cfg_err
   );
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen -- multi-channel LED driver with OFF/ON/BLINK/PWM modes.
// A shared prescaler produces a tick every DIV clocks; every channel advances its
// phase counter on the cycle where tick is high.
//   clk     : clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   cfg     : configuration write channel (slave side)
//   led_out : registered LED drive, bit i = channel i
//   tick    : registered one-cycle strobe per prescaler wrap
module led_pattern_gen #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DIV    = 4,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   led_pattern_gen_if.slave    cfg,
   output logic [NUM_CH-1:0]   led_out,
   output logic                tick
);

   typedef enum logic [1:0] {ModeOff, ModeOn, ModeBlink, ModePwm} mode_e;

   localparam int unsigned       PrescW   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PrescW-1:0] PrescMax = PrescW'(DIV - 1);
   localparam logic [5:0]        NumChW   = 6'(NUM_CH);

   logic [PrescW-1:0] presc_q, presc_d;
   logic              tick_q, tick_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic              accept, ch_ok;

   mode_e             mode_q   [NUM_CH];
   mode_e             mode_d   [NUM_CH];
   logic [CNT_W-1:0]  period_q [NUM_CH];
   logic [CNT_W-1:0]  period_d [NUM_CH];
   logic [CNT_W-1:0]  duty_q   [NUM_CH];
   logic [CNT_W-1:0]  duty_d   [NUM_CH];
   logic [CNT_W-1:0]  phase_q  [NUM_CH];
   logic [CNT_W-1:0]  phase_d  [NUM_CH];
   logic [CNT_W-1:0]  phase_nx [NUM_CH];
   logic [NUM_CH-1:0] led_q, led_d;

   // Prescaler and handshake control.
   always_comb begin
      presc_d = (presc_q == PrescMax) ? '0 : presc_q + 1'b1;
      tick_d  = (presc_q == PrescMax);
      ch_ok   = ({1'b0, cfg.cfg_ch} < NumChW);
      accept  = cfg.cfg_valid && ready_q;
      // Ready drops for the cycle after every accept: at most one write per 2 clks.
      ready_d = !accept;
      err_d   = accept && !ch_ok;
   end

   // Per-channel next state. A write to a channel wins over a tick in the same cycle.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         mode_d[i]   = mode_q[i];
         period_d[i] = period_q[i];
         duty_d[i]   = duty_q[i];
         phase_d[i]  = phase_q[i];
         led_d[i]    = led_q[i];
         phase_nx[i] = (phase_q[i] == period_q[i]) ? '0 : phase_q[i] + 1'b1;

         if (accept && ch_ok && (cfg.cfg_ch == 5'(i))) begin
            mode_d[i]   = mode_e'(cfg.cfg_mode);
            period_d[i] = cfg.cfg_period;
            duty_d[i]   = cfg.cfg_duty;
            phase_d[i]  = '0;
            led_d[i]    = (mode_e'(cfg.cfg_mode) == ModeOn);
         end else if (tick_q) begin
            unique case (mode_q[i])
               ModeOff: led_d[i] = 1'b0;
               ModeOn:  led_d[i] = 1'b1;
               ModeBlink: begin
                  phase_d[i] = phase_nx[i];
                  if (phase_q[i] == period_q[i]) begin
                     led_d[i] = !led_q[i];
                  end
               end
               ModePwm: begin
                  phase_d[i] = phase_nx[i];
                  led_d[i]   = (phase_nx[i] < duty_q[i]);
               end
               default: led_d[i] = 1'b0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         led_q   <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            mode_q[i]   <= ModeBlink;
            period_q[i] <= '0;
            duty_q[i]   <= '0;
            phase_q[i]  <= '0;
         end
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         led_q   <= led_d;
         for (int i = 0; i < NUM_CH; i++) begin
            mode_q[i]   <= mode_d[i];
            period_q[i] <= period_d[i];
            duty_q[i]   <= duty_d[i];
            phase_q[i]  <= phase_d[i];
         end
      end
   end

   assign led_out       = led_q;
   assign tick          = tick_q;
   assign cfg.cfg_ready = ready_q;
   assign cfg.cfg_err   = err_q;

endmodule
